// File: rtl/signal_expander.sv
// Pulse stretcher: SIG_OUT follows SIG_IN and stays high EXTEND_LEN extra
// cycles after SIG_IN falls, using a saturating down-counter.
module signal_expander #(
  parameter int MAX_EXTEND_LEN_WIDTH = 5
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
  input  logic                            SIG_IN,
  output logic                            SIG_OUT
);

  localparam int W = MAX_EXTEND_LEN_WIDTH;
  localparam logic [W-1:0] CNT_ZERO = W'(1'b0);
  localparam logic [W-1:0] CNT_ONE  = W'(1'b1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  logic         out_next;

  // Next-state: a trigger reloads the window; otherwise count down to zero without wrapping.
  always_comb begin
    cnt_next = cnt;
    out_next = 1'b0;
    if (SIG_IN) begin
      cnt_next = EXTEND_LEN;
      out_next = 1'b1;
    end else if (cnt != CNT_ZERO) begin
      cnt_next = cnt - CNT_ONE;
      out_next = 1'b1;
    end else begin
      cnt_next = CNT_ZERO;
      out_next = 1'b0;
    end
  end

  // State and output registers; RESETN is active-high despite its name.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      cnt     <= CNT_ZERO;
      SIG_OUT <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      SIG_OUT <= out_next;
    end
  end

endmodule

// File: tb/tb_signal_expander.sv
// Scoreboard bench for signal_expander: the reference model tracks the time
// since the last trigger and the length sampled with it.
module tb_signal_expander;

  localparam int W = 5;

  logic         CLK;
  logic         RESETN;
  logic [W-1:0] EXTEND_LEN;
  logic         SIG_IN;
  logic         SIG_OUT;

  int compared   = 0;
  int mismatched = 0;

  logic exp_q[$];
  int   cyc       = 0;
  int   last_trig = -1;
  int   last_len  = 0;

  signal_expander #(.MAX_EXTEND_LEN_WIDTH(W)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .EXTEND_LEN(EXTEND_LEN),
    .SIG_IN(SIG_IN),
    .SIG_OUT(SIG_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic got, input logic want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0b expected %0b", name, got, want);
    end
  endtask

  // Model: output is high iff the last trigger since reset is within its sampled length.
  task automatic step(input logic s, input logic [W-1:0] l);
    logic e;
    @(negedge CLK);
    SIG_IN     = s;
    EXTEND_LEN = l;
    cyc++;
    if (s) begin
      last_trig = cyc;
      last_len  = int'(l);
    end
    e = (last_trig >= 0) && ((cyc - last_trig) <= last_len);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    last_trig = -1;
    last_len  = 0;
  endtask

  // Monitor: one output per clock edge while expectations are pending.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        logic e;
        e = exp_q.pop_front();
        check($sformatf("sig_out_cyc%0d", cyc), SIG_OUT, e);
      end
    end
  end

  initial begin
    RESETN     = 1'b1;
    SIG_IN     = 1'b0;
    EXTEND_LEN = 5'd0;
    #1;
    check("reset_state", SIG_OUT, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b0;
    model_reset();

    // Idle after reset.
    for (int i = 0; i < 3; i++) step(1'b0, 5'd3);

    // Single-cycle pulse, length 3.
    step(1'b1, 5'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd3);

    // Long pulse, length 5.
    for (int i = 0; i < 10; i++) step(1'b1, 5'd5);
    for (int i = 0; i < 8; i++) step(1'b0, 5'd5);

    // Length 0: pure one-cycle delay.
    step(1'b1, 5'd0); step(1'b0, 5'd0); step(1'b1, 5'd0);
    step(1'b1, 5'd0); step(1'b0, 5'd0); step(1'b0, 5'd0);

    // Merge with gap 3, then split with gap 6, length 4.
    step(1'b1, 5'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd4);
    step(1'b1, 5'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd4);
    step(1'b1, 5'd4);
    for (int i = 0; i < 7; i++) step(1'b0, 5'd4);

    // Maximum length, with EXTEND_LEN changed mid-countdown.
    step(1'b1, 5'd31);
    for (int i = 0; i < 10; i++) step(1'b0, 5'd31);
    for (int i = 0; i < 25; i++) step(1'b0, 5'd2);

    // Asynchronous reset mid-countdown.
    step(1'b1, 5'd10);
    step(1'b0, 5'd10);
    step(1'b0, 5'd10);
    @(negedge CLK);
    #2;
    check("pre_reset_high", SIG_OUT, 1'b1);
    RESETN = 1'b1;
    SIG_IN = 1'b0;
    #1;
    check("reset_async", SIG_OUT, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 5'd10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic         s;
      logic [W-1:0] l;
      s = ($urandom_range(0, 99) < 25);
      l = W'($urandom_range(0, 31));
      step(s, l);
    end
    for (int i = 0; i < 34; i++) step(1'b0, W'($urandom_range(0, 31)));

    // Drain: every expectation must have been consumed.
    repeat (3) @(posedge CLK);
    #2;
    check("queue_drained", (exp_q.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/signal_expander.md
# signal_expander

Pulse-stretching block for the trigger path. It holds SIG_OUT asserted for as long as SIG_IN is asserted, plus EXTEND_LEN extra clock cycles after SIG_IN deasserts. Single clock domain. It sits in front of the data-frame generator, which uses the stretched trigger to define the acquisition window.

## Interface
Parameters:
- MAX_EXTEND_LEN_WIDTH, default 5: width of EXTEND_LEN and of the internal down-counter. Must be ≥ 1.

Ports:
- CLK  input  1  sole clock; all state updates on its rising edge.
- RESETN  input  1  reset, asynchronous and active-high despite the name. RESETN=1 immediately clears all state.
- EXTEND_LEN  input  MAX_EXTEND_LEN_WIDTH  number of extra cycles SIG_OUT stays high after SIG_IN falls; unsigned.
- SIG_IN  input  1  level/pulse to be stretched.
- SIG_OUT  output  1  registered, stretched version of SIG_IN.

## Operation
- State consists of a down-counter `cnt` (MAX_EXTEND_LEN_WIDTH bits) and the SIG_OUT register.
- While RESETN=1, asynchronously: `cnt`=0 and SIG_OUT=0. Both stay there until RESETN=0.
- On each rising CLK edge with RESETN=0, exactly one of the following applies, in priority order:
  - If SIG_IN=1: `cnt` loads EXTEND_LEN and SIG_OUT becomes 1.
  - Else if `cnt`≠0: `cnt` decrements by 1 and SIG_OUT becomes 1.
  - Else: `cnt` stays 0 and SIG_OUT becomes 0.
- Retrigger: SIG_IN=1 while a countdown is in progress reloads `cnt` with the current EXTEND_LEN. The window restarts, with no gap on SIG_OUT.
- EXTEND_LEN is sampled only on edges where SIG_IN=1. Changing it mid-countdown does not alter the countdown in progress.
- EXTEND_LEN=0: SIG_OUT is SIG_IN delayed by one cycle, with no stretching.
- Maximum EXTEND_LEN (2^W−1) is legal and gives the full stretch. The counter never wraps, because decrement only occurs when `cnt`≠0.
- The design has no other FSM states; behaviour is fully defined by `cnt` and SIG_IN.

## Timing
- Latency: SIG_OUT rises at the first CLK edge that samples SIG_IN=1, one cycle after SIG_IN is presented.
- SIG_IN high for N consecutive sampled edges with constant EXTEND_LEN=L gives:
  - SIG_OUT high for exactly N+L consecutive cycles;
  - SIG_OUT falls at the (L+1)-th edge after the last edge that sampled SIG_IN=1.
- Two SIG_IN pulses separated by a gap of G sampled-low edges, with G ≤ L, merge into one continuous SIG_OUT pulse.
- If G > L, SIG_OUT is low for exactly G−L cycles between the two pulses.
- Reset asserted mid-countdown forces SIG_OUT=0 immediately, without waiting for a CLK edge. After release, the first edge behaves as from idle.
- SIG_OUT is driven only from the register, with no combinational path from any input.

## Test plan
- Reset: assert RESETN=1 mid-operation with SIG_OUT=1 → SIG_OUT=0 before the next CLK edge; after release with SIG_IN=0, SIG_OUT remains 0.
- Single-cycle pulse, EXTEND_LEN=3: SIG_IN=1 for 1 edge → SIG_OUT=1 for exactly 4 cycles starting at that edge, then 0.
- Long pulse, EXTEND_LEN=5: SIG_IN=1 for 10 edges → SIG_OUT=1 for 15 cycles.
- EXTEND_LEN=0: SIG_IN pattern 1,0,1,1,0 → SIG_OUT is the same pattern delayed one cycle.
- Retrigger/merge, EXTEND_LEN=4: pulses of 1 edge separated by 3 low edges → one continuous SIG_OUT pulse. With 6 low edges between pulses instead → a 2-cycle low gap between two SIG_OUT pulses.
- Boundary, W=5 and EXTEND_LEN=31: 1-edge pulse → SIG_OUT high 32 cycles, no wrap. Changing EXTEND_LEN to 2 mid-countdown leaves the 32-cycle window unchanged.
